// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one binary-to-BCD converter among
// NUM_REQ requesters, with a watchdog on the converter's data-valid.
// Ports:
//   i_Clock, i_Rst_n      clock (rising edge), async active-low reset
//   i_Req, i_Req_Binary   per-requester request level and packed operands
//   o_Ack                 one-cycle grant pulse for the winning requester
//   o_Done / o_Error      one-cycle completion / timeout pulse for that requester
//   o_BCD                 last captured converter result
//   o_Busy                high from grant until done/error
//   o_Conv_Start          one-cycle start pulse to the converter
//   o_Conv_Binary         latched operand driven to the converter
//   i_Conv_DV, i_Conv_BCD converter data-valid and result
module bcd_conv_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic [NUM_REQ-1:0]            i_Req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_Req_Binary,
  output logic [NUM_REQ-1:0]            o_Ack,
  output logic [NUM_REQ-1:0]            o_Done,
  output logic [NUM_REQ-1:0]            o_Error,
  output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
  output logic                          o_Busy,
  output logic                          o_Conv_Start,
  output logic [INPUT_WIDTH-1:0]        o_Conv_Binary,
  input  logic                          i_Conv_DV,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_Conv_BCD
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BCD_W = DECIMAL_DIGITS * 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_FINISH
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ok_q, ok_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [NUM_REQ-1:0]     err_q, err_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   busy_q, busy_d;
  logic                   start_q, start_d;
  logic [INPUT_WIDTH-1:0] bin_q, bin_d;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [SUM_W-1:0]       sum;
  logic [IDX_W-1:0]       cand;

  // Round-robin search: first active request at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!win_found && i_Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      bin_q   <= bin_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    bin_d   = bin_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (win_found) begin
          idx_d   = win_idx;
          bin_d   = i_Req_Binary[win_idx*INPUT_WIDTH +: INPUT_WIDTH];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        ack_d   = NUM_REQ'(1) << idx_q;
        busy_d  = 1'b1;
        // Re-sample on the ack edge; requester holds the operand until then.
        bin_d   = i_Req_Binary[idx_q*INPUT_WIDTH +: INPUT_WIDTH];
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = S_START;
      end
      S_START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The cycle carrying the start pulse is not a wait cycle: DV is ignored
        // and the watchdog does not advance.
        if (start_q) begin
          cnt_d = cnt_q;
        end else if (i_Conv_DV) begin
          bcd_d   = i_Conv_BCD;
          ok_d    = 1'b1;
          state_d = S_FINISH;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          ok_d    = 1'b0;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        if (ok_q) done_d = NUM_REQ'(1) << idx_q;
        else      err_d  = NUM_REQ'(1) << idx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_Ack         = ack_q;
  assign o_Done        = done_q;
  assign o_Error       = err_q;
  assign o_BCD         = bcd_q;
  assign o_Busy        = busy_q;
  assign o_Conv_Start  = start_q;
  assign o_Conv_Binary = bin_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter with a behavioural converter.
module tb_bcd_conv_arbiter;

  localparam int TO = 255;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] req_bin;
  logic        conv_dv;
  logic [11:0] conv_bcd;
  logic [1:0]  ack, done, err;
  logic [11:0] bcd;
  logic        busy, cstart;
  logic [7:0]  cbin;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int          ack_hist[$];
  int          done_idx_hist[$];
  int          err_hist[$];
  logic [11:0] done_bcd_hist[$];
  int          ack_cyc, done_cyc, err_cyc, start_cnt, multi_hot;

  int          conv_delay;
  bit          dv_on_start;
  int          spur_req, spur_done, model_cnt;
  logic [7:0]  model_op;

  bcd_conv_arbiter #(
    .NUM_REQ(2), .INPUT_WIDTH(8), .DECIMAL_DIGITS(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Req_Binary(req_bin),
    .o_Ack(ack), .o_Done(done), .o_Error(err), .o_BCD(bcd), .o_Busy(busy),
    .o_Conv_Start(cstart), .o_Conv_Binary(cbin),
    .i_Conv_DV(conv_dv), .i_Conv_BCD(conv_bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic int idx_of(input logic [1:0] v);
    for (int i = 0; i < 2; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Converter model: DV conv_delay negedges after seeing start (0 = never).
  initial begin
    conv_dv = 1'b0; conv_bcd = '0; model_cnt = 0; spur_done = 0; model_op = '0;
    forever begin
      @(negedge clk);
      conv_dv = 1'b0;
      if (!rst_n) begin
        model_cnt = 0;
      end else if (cstart) begin
        model_cnt = conv_delay;
        model_op  = cbin;
        if (dv_on_start) begin conv_dv = 1'b1; conv_bcd = 12'h999; end
      end else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) begin conv_dv = 1'b1; conv_bcd = to_bcd(model_op); end
      end else if (spur_req != spur_done) begin
        spur_done = spur_req;
        conv_dv   = 1'b1;
        conv_bcd  = 12'h999;
      end
    end
  end

  // Event recorder.
  initial begin
    ack_cyc = 0; done_cyc = 0; err_cyc = 0; start_cnt = 0; multi_hot = 0;
    forever begin
      @(negedge clk);
      if ($countones({ack, done, err}) > 1) multi_hot++;
      if (|ack) begin ack_hist.push_back(idx_of(ack)); ack_cyc = cyc; end
      if (|done) begin
        done_idx_hist.push_back(idx_of(done));
        done_bcd_hist.push_back(bcd);
        done_cyc = cyc;
      end
      if (|err) begin err_hist.push_back(idx_of(err)); err_cyc = cyc; end
      if (cstart) start_cnt++;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    int a0;
    a0 = ack_hist.size();
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (ack_hist.size() > a0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    int d0, e0;
    d0 = done_idx_hist.size();
    e0 = err_hist.size();
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (done_idx_hist.size() > d0 || err_hist.size() > e0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) tick;
    vectors++;
    if ({ack, done, err, bcd, busy, cstart, cbin} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_asserted: got %h want 0", {ack, done, err, bcd, busy, cstart, cbin});
    end
    rst_n = 1'b1;
    repeat (4) tick;
    vectors++;
    if ({ack, done, err, bcd, busy, cstart, cbin} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want 0", {ack, done, err, bcd, busy, cstart, cbin});
    end
  endtask

  task automatic test_round_robin;
    int a0, d0;
    do_reset;
    conv_delay = 10;
    req_bin = {8'd200, 8'd7};
    a0 = ack_hist.size();
    d0 = done_idx_hist.size();
    req = 2'b11;
    for (int i = 0; i < 400 && done_idx_hist.size() < d0 + 4; i++) tick;
    req = 2'b00;
    repeat (3) tick;
    vectors++;
    if (done_idx_hist.size() !== d0 + 4 || ack_hist.size() !== a0 + 4) begin
      miscompares++;
      $display("FAIL rr_count: got acks %0d dones %0d want 4 4",
               ack_hist.size() - a0, done_idx_hist.size() - d0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (ack_hist[a0+k] !== k % 2 || done_idx_hist[d0+k] !== k % 2 ||
            done_bcd_hist[d0+k] !== ((k % 2) ? 12'h200 : 12'h007)) begin
          miscompares++;
          $display("FAIL rr_grant%0d: got ack %0d done %0d bcd %h want idx %0d bcd %h", k,
                   ack_hist[a0+k], done_idx_hist[d0+k], done_bcd_hist[d0+k], k % 2,
                   (k % 2) ? 12'h200 : 12'h007);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_busy_after: got %b want 0", busy);
    end
  endtask

  task automatic test_single;
    bit ok;
    int s0;
    conv_delay = 40;
    req_bin[7:0] = 8'hFF;
    s0 = start_cnt;
    req = 2'b01;
    wait_ack(10, ok);
    vectors++;
    if (!ok || ack !== 2'b01 || cbin !== 8'hFF || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ack: got ok %b ack %b bin %h busy %b want 1 01 ff 1", ok, ack, cbin, busy);
    end
    req = 2'b00;
    tick;
    vectors++;
    if (ack !== 2'b00) begin
      miscompares++;
      $display("FAIL single_ack_width: got %b want 00", ack);
    end
    wait_finish(100, ok);
    vectors++;
    if (!ok || done !== 2'b01 || bcd !== 12'h255) begin
      miscompares++;
      $display("FAIL single_done: got ok %b done %b bcd %h want 1 01 255", ok, done, bcd);
    end
    vectors++;
    if (done_cyc - ack_cyc !== 43) begin
      miscompares++;
      $display("FAIL single_latency: got %0d want 43", done_cyc - ack_cyc);
    end
    tick;
    vectors++;
    if (done !== 2'b00 || busy !== 1'b0 || start_cnt - s0 !== 1) begin
      miscompares++;
      $display("FAIL single_after: got done %b busy %b starts %0d want 00 0 1", done, busy, start_cnt - s0);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int d0;
    conv_delay = 0;
    req_bin[15:8] = 8'd42;
    d0 = done_idx_hist.size();
    req = 2'b10;
    wait_ack(10, ok);
    vectors++;
    if (!ok || ack !== 2'b10) begin
      miscompares++;
      $display("FAIL to_ack: got ok %b ack %b want 1 10", ok, ack);
    end
    req = 2'b00;
    wait_finish(400, ok);
    vectors++;
    if (!ok || err !== 2'b10 || bcd !== 12'h255 || done_idx_hist.size() !== d0) begin
      miscompares++;
      $display("FAIL to_error: got ok %b err %b bcd %h dones %0d want 1 10 255 0",
               ok, err, bcd, done_idx_hist.size() - d0);
    end
    vectors++;
    if (err_cyc - ack_cyc !== TO + 3) begin
      miscompares++;
      $display("FAIL to_latency: got %0d want %0d", err_cyc - ack_cyc, TO + 3);
    end
    conv_delay = 5;
    req_bin[7:0] = 8'd99;
    req = 2'b01;
    wait_ack(10, ok);
    req = 2'b00;
    wait_finish(100, ok);
    vectors++;
    if (!ok || done !== 2'b01 || bcd !== 12'h099) begin
      miscompares++;
      $display("FAIL to_recover: got ok %b done %b bcd %h want 1 01 099", ok, done, bcd);
    end
  endtask

  task automatic test_collision;
    bit ok;
    int e0;
    conv_delay = TO;
    dv_on_start = 1'b1;
    req_bin[15:8] = 8'd128;
    e0 = err_hist.size();
    req = 2'b10;
    wait_ack(10, ok);
    req = 2'b00;
    tick;
    dv_on_start = 1'b0;
    wait_finish(400, ok);
    vectors++;
    if (!ok || done !== 2'b10 || bcd !== 12'h128 || err_hist.size() !== e0) begin
      miscompares++;
      $display("FAIL coll_done: got ok %b done %b bcd %h errs %0d want 1 10 128 0",
               ok, done, bcd, err_hist.size() - e0);
    end
    vectors++;
    if (done_cyc - ack_cyc !== TO + 3) begin
      miscompares++;
      $display("FAIL coll_latency: got %0d want %0d", done_cyc - ack_cyc, TO + 3);
    end
  endtask

  task automatic test_dropped;
    bit ok;
    int a1, d1;
    conv_delay = 30;
    req_bin = {8'd11, 8'd63};
    req = 2'b01;
    wait_ack(10, ok);
    req = 2'b00;
    a1 = ack_hist.size();
    repeat (3) tick;
    req = 2'b10;
    repeat (3) tick;
    req = 2'b00;
    wait_finish(100, ok);
    vectors++;
    if (!ok || done !== 2'b01 || bcd !== 12'h063) begin
      miscompares++;
      $display("FAIL drop_done: got ok %b done %b bcd %h want 1 01 063", ok, done, bcd);
    end
    repeat (3) tick;
    d1 = done_idx_hist.size();
    spur_req++;
    repeat (5) tick;
    vectors++;
    if (ack_hist.size() !== a1 || done_idx_hist.size() !== d1 || bcd !== 12'h063 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_spurious: got acks %0d dones %0d bcd %h busy %b want 0 0 063 0",
               ack_hist.size() - a1, done_idx_hist.size() - d1, bcd, busy);
    end
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    conv_delay = 100;
    req_bin[7:0] = 8'd5;
    req = 2'b01;
    wait_ack(10, ok);
    req = 2'b00;
    repeat (10) tick;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ack, done, err, bcd, busy, cstart, cbin} !== 28'h0) begin
      miscompares++;
      $display("FAIL rst_async: got %h want 0", {ack, done, err, bcd, busy, cstart, cbin});
    end
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    conv_delay = 8;
    req_bin = {8'd77, 8'd5};
    req = 2'b11;
    wait_ack(10, ok);
    vectors++;
    if (!ok || ack !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_priority: got ok %b ack %b want 1 01", ok, ack);
    end
    req = 2'b00;
    wait_finish(100, ok);
    vectors++;
    if (!ok || done !== 2'b01 || bcd !== 12'h005) begin
      miscompares++;
      $display("FAIL rst_fresh: got ok %b done %b bcd %h want 1 01 005", ok, done, bcd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_bin = '0;
    conv_delay = 0;
    dv_on_start = 1'b0;
    spur_req = 0;
    test_reset;
    test_round_robin;
    test_single;
    test_timeout;
    test_collision;
    test_dropped;
    test_reset_mid_wait;
    vectors++;
    if (multi_hot !== 0) begin
      miscompares++;
      $display("FAIL onehot_pulses: got %0d multi-hot cycles want 0", multi_hot);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
